// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the encoder stream and decoder.
// Codeword index is Hamming position minus one.
package hamming_pkg;

   localparam int HAM_DATA_W = 4;
   localparam int HAM_CODE_W = 7;

   localparam int P1_IDX = 0;
   localparam int P2_IDX = 1;
   localparam int D0_IDX = 2;
   localparam int P4_IDX = 3;
   localparam int D1_IDX = 4;
   localparam int D2_IDX = 5;
   localparam int D3_IDX = 6;

   typedef struct packed {
      logic                  injected;
      logic [HAM_CODE_W-1:0] code;
   } ham_word_t;

   function automatic logic [HAM_CODE_W-1:0] ham74_encode(
      input logic [HAM_DATA_W-1:0] d
   );
      logic [HAM_CODE_W-1:0] c;
      c         = '0;
      c[D0_IDX] = d[0];
      c[D1_IDX] = d[1];
      c[D2_IDX] = d[2];
      c[D3_IDX] = d[3];
      c[P1_IDX] = d[0] ^ d[1] ^ d[3];
      c[P2_IDX] = d[0] ^ d[2] ^ d[3];
      c[P4_IDX] = d[1] ^ d[2] ^ d[3];
      return c;
   endfunction

   // Syndrome {s4,s2,s1} names the errored Hamming position.
   function automatic logic [2:0] ham74_syndrome(
      input logic [HAM_CODE_W-1:0] c
   );
      logic [2:0] s;
      s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
      s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
      s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
      return s;
   endfunction

   function automatic logic [HAM_DATA_W-1:0] ham74_decode(
      input logic [HAM_CODE_W-1:0] c
   );
      logic [2:0]            s;
      logic [HAM_CODE_W-1:0] f;
      s = ham74_syndrome(c);
      f = c;
      if (s != 3'd0)
         f = c ^ (7'b1 << (s - 3'd1));
      return {f[D3_IDX], f[D2_IDX], f[D1_IDX], f[D0_IDX]};
   endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is always visible on rdata.
// Full blocks push even when a pop happens in the same cycle.
module hamming_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                  (wptr[AW] != rptr[AW]);
   assign empty = (wptr == rptr);
   assign level = wptr - rptr;
   assign rdata = mem[rptr[AW-1:0]];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
            wptr              <= wptr + 1'b1;
         end
         if (do_pop)
            rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(7,4) encoder with output FIFO and one-shot
// error injection for link and decoder testing.
module hamming_encoder_stream
   import hamming_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_data,
   input  logic                   inj_valid,
   input  logic [6:0]             inj_mask,
   output logic                   inj_armed,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [6:0]             out_code,
   output logic                   out_injected,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [CNT_W-1:0]       word_count
);

   logic       ready_en;
   logic       full;
   logic       empty;
   logic       accept;
   logic       pop;
   logic [6:0] mask_q;
   logic [6:0] applied;
   ham_word_t  wr_word;
   ham_word_t  hd_word;

   assign in_ready = ready_en && !full;
   assign accept   = in_valid && in_ready;
   assign applied  = inj_armed ? mask_q : 7'd0;

   assign wr_word.code     = ham74_encode(in_data) ^ applied;
   assign wr_word.injected = |applied;

   assign out_valid    = !empty;
   assign pop          = out_valid && out_ready;
   assign out_code     = hd_word.code;
   assign out_injected = hd_word.injected;

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ready_en <= 1'b0;
      else
         ready_en <= 1'b1;
   end

   // A new arm wins over consumption so same-cycle arms survive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q    <= '0;
         inj_armed <= 1'b0;
      end else if (inj_valid) begin
         mask_q    <= inj_mask;
         inj_armed <= 1'b1;
      end else if (accept) begin
         inj_armed <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         word_count <= '0;
      else if (accept)
         word_count <= word_count + 1'b1;
   end

   hamming_sync_fifo #(
      .WIDTH ($bits(ham_word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .wdata (wr_word),
      .pop   (pop),
      .rdata (hd_word),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

endmodule

// File: doc/hamming_encoder_stream.md
Name: hamming_encoder_stream

Overview:
Streaming Hamming(7,4) encoder: the transmit-side counterpart of the team's hamming_decoder. It accepts 4-bit data words over a valid/ready handshake, computes the 7-bit codeword and buffers codewords in a small FIFO for downstream valid/ready consumers. A single-shot error-injection mask lets benches and link tests feed deliberately corrupted codewords to the decoder.

Parameters:
DEPTH, 4, output FIFO entries; power of two, >= 2
CNT_W, 16, width of accepted-word counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  encoder can accept a word
in_data  in  4  data nibble d3..d0
inj_valid  in  1  arm an error-injection mask (pulse)
inj_mask  in  7  bit flips XORed into the next codeword
inj_armed  out  1  a mask is pending
out_valid  out  1  codeword valid
out_ready  in  1  downstream accepts codeword
out_code  out  7  codeword, possibly corrupted
out_injected  out  1  out_code carries a nonzero injected mask
fifo_level  out  $clog2(DEPTH)+1  current occupancy
word_count  out  CNT_W  words accepted since reset

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n. While rst_n=0: FIFO empty, in_ready=0, out_valid=0, out_code=0, out_injected=0, inj_armed=0, fifo_level=0, word_count=0. in_ready rises in the first cycle after deassertion.
- Codeword bit mapping (index = Hamming position-1): code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4, code[4]=d1, code[5]=d2, code[6]=d3.
- Parity bits: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3. The decoder syndrome {s4,s2,s1} gives the errored position.
- Accept: a word is accepted when in_valid && in_ready. in_ready = !full. A pop in the same cycle does not free space for a push when full.
- On accept, the encoded codeword XOR the applied mask is written to the FIFO tail, with flag (applied mask != 0).
- word_count increments on accept and wraps modulo 2^CNT_W.
- Latency: a word accepted at edge N is on out_code/out_valid after edge N when the FIFO was empty (1 cycle).
- Output: out_code, out_injected and out_valid always reflect the FIFO head. A pop occurs when out_valid && out_ready.
- out_code and out_valid are held stable while out_valid && !out_ready.
- When the FIFO is empty: out_valid=0 and out_code holds its last value (don't-care).
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and order is preserved.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- Injection: inj_valid captures inj_mask and sets inj_armed. The armed mask applies to the first word accepted in a later cycle, then inj_armed clears.
- inj_valid in the same cycle as an accept: the current word uses the previously armed mask (or none), and the new mask becomes armed.
- inj_valid while already armed overwrites the mask.
- inj_mask=0 arms and is consumed like any other mask, but out_injected stays 0.
- No reset mid-operation recovery beyond the async clear: all in-flight words are dropped.

Decomposition:
- Package hamming_pkg:
  - constants HAM_DATA_W=4 and HAM_CODE_W=7
  - parameters for bit positions P1_IDX, P2_IDX, D0_IDX, P4_IDX, D1_IDX, D2_IDX, D3_IDX
  - function ham74_encode(data) returning the codeword; the decoder is refactored onto the same package.
- Sub-module hamming_sync_fifo:
  - parameterised WIDTH/DEPTH, 8-bit payload {injected, code}
  - same clk/rst_n
  - ports: push, pop, full, empty, level.

Test Plan:
- Exhaustive encode: feed 0..15 with out_ready=1. Required codewords include 0000->0000000, 0001->0000111, 1000->1001011, 1011->1010101, 1111->1111111. Each appears 1 cycle after accept; word_count=16.
- Backpressure, DEPTH=4: hold out_ready=0 and push 6 words. in_ready drops after 4 and fifo_level=4. Release out_ready: the 4 words drain in order, then the remaining 2 are accepted.
- Injection: arm inj_mask=7'b0001000, then send 1011. The output is 1010101^0001000=1011101 with out_injected=1. The next word 1011 outputs 1010101 with out_injected=0. The hamming_decoder returns syndrome 100, data 1011.
- Same-cycle arm+accept: inj_valid with mask 0000001 together with accepting 0000. The output is 0000000 with injected=0. The next accept of 0000 outputs 0000001 with injected=1.
- Reset mid-stream: with 3 words queued, pulse rst_n low asynchronously (between edges). out_valid, fifo_level, word_count and inj_armed drop to 0 immediately, and in_ready returns one cycle after release.
- Stall stability: hold out_ready=0 for 5 cycles with a word present. out_code and out_valid are unchanged every cycle. The simultaneous push/pop steady state keeps fifo_level constant.
